// File: rtl/rng_pool.sv
// Post-mixer random pool: warm-up discard, repetition-count health test,
// and a first-word-fall-through FIFO drained by a valid/ready consumer.
module rng_pool #(
  parameter int DEPTH     = 8,
  parameter int WARMUP    = 16,
  parameter int REP_LIMIT = 4,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      rand_num_i,
  input  logic             rand_num_valid_i,
  input  logic             alarm_clear_i,
  output logic [63:0]      rand_o,
  output logic             rand_valid_o,
  input  logic             rand_ready_i,
  output logic [CNT_W-1:0] fifo_count_o,
  output logic             alarm_o,
  output logic [15:0]      drop_cnt_o,
  output logic [1:0]       pool_state_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_ALARM  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [WARM_W-1:0]  warm_cnt_reg;
  logic [REP_W-1:0]   rep_cnt_reg;
  logic [REP_W-1:0]   rep_cnt_next;
  logic [63:0]        last_word_reg;
  logic [63:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [15:0]        drop_cnt_reg;

  logic sample_live;
  logic trip;
  logic full;
  logic push;
  logic pop;

  always_comb begin
    sample_live  = rand_num_valid_i && (state_reg != ST_ALARM);
    rep_cnt_next = REP_W'(1);
    if (rep_cnt_reg != '0 && rand_num_i == last_word_reg)
      rep_cnt_next = rep_cnt_reg + 1'b1;
    trip = sample_live && (rep_cnt_next == REP_W'(REP_LIMIT));
    // Fullness uses the pre-edge count, so a same-cycle pop never makes room.
    full = (count_reg == CNT_W'(DEPTH));
    pop  = rand_valid_o && rand_ready_i;
    push = sample_live && (state_reg == ST_RUN) && !trip && !full;
  end

  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem[wr_ptr_reg] <= rand_num_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_WARMUP;
      warm_cnt_reg  <= '0;
      rep_cnt_reg   <= '0;
      last_word_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      drop_cnt_reg  <= '0;
    end else if (state_reg == ST_ALARM) begin
      if (alarm_clear_i) begin
        state_reg    <= ST_WARMUP;
        warm_cnt_reg <= '0;
        rep_cnt_reg  <= '0;
      end
    end else begin
      if (rand_num_valid_i) begin
        rep_cnt_reg   <= rep_cnt_next;
        last_word_reg <= rand_num_i;
      end
      if (trip) begin
        state_reg  <= ST_ALARM;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (state_reg == ST_WARMUP && rand_num_valid_i) begin
          warm_cnt_reg <= warm_cnt_reg + 1'b1;
          if (warm_cnt_reg + 1'b1 == WARM_W'(WARMUP))
            state_reg <= ST_RUN;
        end
        if (push)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)
          count_reg <= count_reg + 1'b1;
        else if (!push && pop)
          count_reg <= count_reg - 1'b1;
        if (state_reg == ST_RUN && rand_num_valid_i && full && drop_cnt_reg != 16'hFFFF)
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign rand_valid_o = (state_reg == ST_RUN) && (count_reg != '0);
  assign rand_o       = (count_reg != '0) ? mem[rd_ptr_reg] : 64'd0;
  assign fifo_count_o = count_reg;
  assign alarm_o      = (state_reg == ST_ALARM);
  assign drop_cnt_o   = drop_cnt_reg;
  assign pool_state_o = state_reg;

endmodule

// File: doc/rng_pool.md
Name: rng_pool

Overview:
- Consumer stage directly downstream of the entropy-mixing block (rng_cs). It takes the mixed 64-bit random word and its valid flag.
- It discards a warm-up window of samples after reset. It then runs a repetition-count health test on every valid sample.
- Accepted words go into a first-word-fall-through FIFO. Ariane-side consumers drain the FIFO with a valid/ready handshake.
- On a health-test failure the block flushes its contents and blocks output until software clears the alarm.

Parameters:
- DEPTH, 8: FIFO entries. Power of 2, minimum 2.
- WARMUP, 16: valid samples discarded after reset or alarm clear. Minimum 1.
- REP_LIMIT, 4: consecutive identical valid samples that trip the alarm. Minimum 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- rand_num_i  in  64  mixed random word from rng_cs
- rand_num_valid_i  in  1  rand_num_i valid; each high cycle is one sample
- alarm_clear_i  in  1  pulse; leaves ALARM state
- rand_o  out  64  FIFO head word
- rand_valid_o  out  1  FIFO non-empty and state is RUN
- rand_ready_i  in  1  consumer accepts rand_o this cycle
- fifo_count_o  out  CNT_W  occupancy, 0..DEPTH
- alarm_o  out  1  high while in ALARM
- drop_cnt_o  out  16  saturating count of samples dropped because the FIFO was full
- pool_state_o  out  2  0=WARMUP, 1=RUN, 2=ALARM (debug)

Behaviour:
- Reset is rst_n, synchronous, active-low, on clock clk.
- Reset values:
  - state=WARMUP, warm_cnt=0, rep_cnt=0, last_word=0
  - wr_ptr=rd_ptr=0, count=0, drop_cnt=0
  - outputs: rand_valid_o=0, rand_o=0, fifo_count_o=0, alarm_o=0, drop_cnt_o=0, pool_state_o=0
- Sample definition: a cycle with rand_num_valid_i=1. Cycles with valid low change nothing on the input side and do not break a repetition run.
- Repetition test (active in WARMUP and RUN; frozen in ALARM):
  - On each sample: if rep_cnt!=0 and rand_num_i==last_word, then rep_cnt++. Otherwise rep_cnt=1.
  - last_word<=rand_num_i.
  - When the updated rep_cnt equals REP_LIMIT: state<=ALARM on the next edge. That sample is not written.
- WARMUP:
  - Each sample increments warm_cnt. Samples are never written.
  - When the sample that makes warm_cnt==WARMUP arrives without tripping the test, state<=RUN. The next sample is the first one eligible for writing.
- RUN, push:
  - A sample that passes the test is written at wr_ptr when count<DEPTH.
  - If count==DEPTH at that edge, the sample is dropped and drop_cnt increments, saturating at 0xFFFF.
  - The full check uses the pre-edge count. A simultaneous pop does not free space for a same-cycle push when full.
- RUN, pop:
  - Pop happens when rand_valid_o && rand_ready_i. rd_ptr advances.
  - rand_o = mem[rd_ptr] combinationally (FWFT). rand_o=0 when count==0.
- Simultaneous push and pop with 0<count<DEPTH: both happen, count unchanged.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately and is never derived from the pointers.
- Entering ALARM (registered):
  - Flush: wr_ptr=rd_ptr=count=0.
  - alarm_o=1, rand_valid_o=0.
  - A pop cannot occur in the trip cycle's effect; ready is ignored from the trip edge onward.
- ALARM:
  - Samples are ignored. drop_cnt is held.
  - alarm_clear_i=1 moves to WARMUP with warm_cnt=0, rep_cnt=0.
  - alarm_clear_i in any other state is ignored.
- rand_valid_o is 0 in WARMUP and ALARM, so pops are impossible there. The FIFO is always empty in WARMUP because entry is only from reset or ALARM.
- Reset mid-operation: all state returns to reset values on the reset edge. FIFO contents are lost and drop_cnt clears.
- Latency: a sample accepted at edge N is visible on rand_o/rand_valid_o after edge N (1 cycle), provided the FIFO was empty.

Test Plan:
- Warm-up: reset, then 16 distinct valid samples 0x1..0x10 → rand_valid_o stays 0, pool_state_o=0→1 after the 16th. Sample 0x11 appears on rand_o next cycle with fifo_count_o=1.
- Fill and drop: RUN, rand_ready_i=0, 10 distinct samples → fifo_count_o=8, drop_cnt_o=2, rand_o equals the first word written.
- Concurrent push/pop: count=8, one sample plus ready in the same cycle → pop occurs, sample dropped, drop_cnt_o+1, count=7. At count=3 the same stimulus gives count=3 with order preserved across pointer wrap.
- Repetition alarm: RUN with count=5, samples A,A,A,A (valid gaps in between allowed) → after the 4th A, alarm_o=1, rand_valid_o=0, fifo_count_o=0, pool_state_o=2. Three A's followed by B → no alarm.
- Alarm clear: ALARM, samples sent → ignored. alarm_clear_i pulse → WARMUP, 16 further samples are discarded before output resumes.
- Reset mid-run: count=6, drop_cnt=3, rst_n=0 for 1 cycle → all outputs return to reset values, and the first 16 post-reset samples are discarded.
